// File: rtl/extint_pipe.sv
// extint_pipe: stallable valid/ready pipeline evaluating fill-literal ('1)
// extension expressions of one operand in an OUT_WIDTH-bit context.
// Optional build macro EXTINT_PIPE_ACC_EN enables the output accumulator
// (acc / acc_count); without it those ports are tied to zero.
module extint_pipe #(
    parameter int WIDTH     = 4,
    parameter int OUT_WIDTH = WIDTH + 1,
    parameter int DEPTH     = 2,
    parameter int SIGNED_IN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [2:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [2:0]             out_op,
    output logic [OUT_WIDTH+7:0]   acc,
    output logic [15:0]            acc_count
);
    localparam logic [OUT_WIDTH-1:0] ALL_ONES = {OUT_WIDTH{1'b1}};

    logic [DEPTH-1:0]     valid_r;
    logic [OUT_WIDTH-1:0] data_r [DEPTH];
    logic [2:0]           op_r   [DEPTH];
    logic [DEPTH-1:0]     adv_s;
    logic                 accept_s;
    logic [OUT_WIDTH-1:0] a_z_s;
    logic [OUT_WIDTH-1:0] result_s;

    // The fill literal makes every expression unsigned, so the operand is
    // always zero-extended, even when it is declared signed internally.
    generate
        if (SIGNED_IN != 0) begin : g_signed
            logic signed [WIDTH-1:0] a_sgn_s;
            assign a_sgn_s = in_data;
            assign a_z_s   = OUT_WIDTH'($unsigned(a_sgn_s));
        end else begin : g_unsigned
            assign a_z_s   = OUT_WIDTH'(in_data);
        end
    endgenerate

    // Evaluate one fill-literal expression; all arithmetic wraps at OUT_WIDTH bits.
    function automatic logic [OUT_WIDTH-1:0] fill_eval(
        input logic [2:0]           op,
        input logic [OUT_WIDTH-1:0] a_z,
        input logic                 a_all_ones
    );
        logic [OUT_WIDTH-1:0] sum;
        logic [OUT_WIDTH-1:0] r;
        sum = a_z + ALL_ONES;
        case (op)
            3'd0:    r = OUT_WIDTH'(1'b1);          // a <= '1 is always true
            3'd1:    r = sum;
            3'd2:    r = a_z;
            3'd3:    r = ALL_ONES;
            3'd4:    r = OUT_WIDTH'(a_all_ones);
            3'd5:    r = sum >> 1;                  // sum truncated before shifting
            3'd6:    r = a_z >> 1;
            3'd7:    r = ALL_ONES >> 1;
            default: r = {OUT_WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign result_s = fill_eval(in_op, a_z_s, &in_data);

    // Stage k advances when any stage from k to the end is empty or the
    // consumer is ready (closed form of the recursive stall chain).
    always_comb begin
        adv_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            logic full_v;
            full_v = 1'b1;
            for (int j = k; j < DEPTH; j++) begin
                full_v = full_v & valid_r[j];
            end
            adv_s[k] = out_ready | ~full_v;
        end
    end

    assign in_ready = adv_s[0] & ~rst;
    assign accept_s = in_valid & in_ready;

    // Pipeline stage registers: load stage 0 on accept, shift on advance, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                data_r[k] <= {OUT_WIDTH{1'b0}};
                op_r[k]   <= 3'd0;
            end
        end else begin
            if (adv_s[0]) begin
                valid_r[0] <= accept_s;
                if (accept_s) begin
                    data_r[0] <= result_s;
                    op_r[0]   <= in_op;
                end else begin
                    data_r[0] <= data_r[0];
                    op_r[0]   <= op_r[0];
                end
            end else begin
                valid_r[0] <= valid_r[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    data_r[k]  <= data_r[k-1];
                    op_r[k]    <= op_r[k-1];
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign out_op    = op_r[DEPTH-1];

`ifdef EXTINT_PIPE_ACC_EN
    logic [OUT_WIDTH+7:0] acc_r;
    logic [15:0]          acc_count_r;

    // Accumulate every delivered result; the count saturates, the sum wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= {(OUT_WIDTH+8){1'b0}};
            acc_count_r <= 16'h0000;
        end else if (out_valid && out_ready) begin
            acc_r <= acc_r + {8'h00, data_r[DEPTH-1]};
            if (acc_count_r != 16'hFFFF) begin
                acc_count_r <= acc_count_r + 16'h0001;
            end else begin
                acc_count_r <= acc_count_r;
            end
        end else begin
            acc_r       <= acc_r;
            acc_count_r <= acc_count_r;
        end
    end

    assign acc       = acc_r;
    assign acc_count = acc_count_r;
`else
    assign acc       = {(OUT_WIDTH+8){1'b0}};
    assign acc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_extint_pipe.sv
// Self-checking bench for extint_pipe: directed vector table, backpressure and
// reset sequences, then randomized traffic against a queue-based reference model.
module tb_extint_pipe;
    localparam int W = 4;
    localparam int N = 5;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic [2:0]   in_op;
    logic         out_ready;
    logic         in_ready, out_valid;
    logic [N-1:0] out_data;
    logic [2:0]   out_op;
    logic [N+7:0] acc;
    logic [15:0]  acc_count;
    logic         in_ready_s, out_valid_s;
    logic [N-1:0] out_data_s;
    logic [2:0]   out_op_s;
    logic [N+7:0] acc_s;
    logic [15:0]  acc_count_s;

    int tests = 0;
    int fails = 0;

    typedef struct { int data; int op; } exp_t;
    exp_t q[$];
    int exp_acc = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    extint_pipe #(.WIDTH(W), .OUT_WIDTH(N), .DEPTH(D), .SIGNED_IN(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_op(out_op), .acc(acc), .acc_count(acc_count));

    extint_pipe #(.WIDTH(W), .OUT_WIDTH(N), .DEPTH(D), .SIGNED_IN(1)) u_dut_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_op(in_op), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_op(out_op_s), .acc(acc_s), .acc_count(acc_count_s));

    // Reference: plain integer arithmetic on the opcode rules.
    function automatic int model(int op, int a);
        int m;
        int r;
        m = (1 << N) - 1;
        case (op)
            0: r = 1;
            1: r = (a + m) % (1 << N);
            2: r = a;
            3: r = m;
            4: r = (a == (1 << W) - 1) ? 1 : 0;
            5: r = ((a + m) % (1 << N)) / 2;
            6: r = a / 2;
            7: r = m / 2;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle monitor: scoreboard of accepted operands vs delivered results.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                exp_acc = 0;
                exp_cnt = 0;
            end else begin
                check("in_ready_occ", int'(in_ready), (q.size() < D || out_ready) ? 1 : 0);
                check("sgn_valid", int'(out_valid_s), int'(out_valid));
                if (out_valid) begin
                    check("sgn_data", int'(out_data_s), int'(out_data));
                    check("sgn_op", int'(out_op_s), int'(out_op));
                end
`ifdef EXTINT_PIPE_ACC_EN
                check("acc_run", int'(acc), exp_acc);
                check("acc_count_run", int'(acc_count), exp_cnt);
`else
                check("acc_off", int'(acc), 0);
                check("acc_count_off", int'(acc_count), 0);
`endif
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_out: got 0x%0h expected no result", out_data);
                    end else begin
                        e = q.pop_front();
                        check("sb_data", int'(out_data), e.data);
                        check("sb_op", int'(out_op), e.op);
                        exp_acc = (exp_acc + int'(out_data)) % (1 << (N + 8));
                        if (exp_cnt < 65535) exp_cnt++;
                    end
                end
                if (in_valid && in_ready) begin
                    e.data = model(int'(in_op), int'(in_data));
                    e.op   = int'(in_op);
                    q.push_back(e);
                end
            end
        end
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [N-1:0] exp;
    } vec_t;

    vec_t tbl[10];
    int   accepted;
    logic [N-1:0] hold_data;
    logic [2:0]   hold_op;
    int   waited;

    initial begin
        tbl[0] = '{op: 3'd1, a: 4'h0, exp: 5'h1F};
        tbl[1] = '{op: 3'd1, a: 4'hA, exp: 5'h09};
        tbl[2] = '{op: 3'd4, a: 4'hF, exp: 5'h01};
        tbl[3] = '{op: 3'd4, a: 4'hE, exp: 5'h00};
        tbl[4] = '{op: 3'd0, a: 4'h8, exp: 5'h01};
        tbl[5] = '{op: 3'd5, a: 4'hA, exp: 5'h04};
        tbl[6] = '{op: 3'd7, a: 4'h5, exp: 5'h0F};
        tbl[7] = '{op: 3'd6, a: 4'h9, exp: 5'h04};
        tbl[8] = '{op: 3'd3, a: 4'h2, exp: 5'h1F};
        tbl[9] = '{op: 3'd2, a: 4'h3, exp: 5'h03};

        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_op = 3'd0; out_ready = 1'b1;
        fork monitor(); join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_op", int'(out_op), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_acc_count", int'(acc_count), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", int'(in_ready), 1);

        // Directed vectors with latency check
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_op = tbl[i].op; in_data = tbl[i].a;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            check("vec_not_early", int'(out_valid), 0);
            @(posedge clk);
            @(negedge clk);
            check("vec_valid", int'(out_valid), 1);
            check("vec_data", int'(out_data), int'(tbl[i].exp));
            check("vec_op", int'(out_op), int'(tbl[i].op));
            check("vec_data_sgn", int'(out_data_s), int'(tbl[i].exp));
        end

        // Backpressure: 4 offers into a stalled 2-deep pipe
        @(posedge clk); #1 out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 3'(i + 1); in_data = 4'(i * 5 + 3);
            @(negedge clk);
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, 2);
        @(negedge clk);
        check("bp_in_ready_low", int'(in_ready), 0);
        hold_data = out_data; hold_op = out_op;
        @(posedge clk); @(negedge clk);
        check("bp_data_stable", int'(out_data), int'(hold_data));
        check("bp_op_stable", int'(out_op), int'(hold_op));
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk); check("bp_drain1", int'(out_valid), 1);
        @(negedge clk); check("bp_drain2", int'(out_valid), 1);
        @(negedge clk); check("bp_drain_empty", int'(out_valid), 0);

        // Reset with two results in flight
        @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd3; in_data = 4'h1;
        @(posedge clk); #1 in_op = 3'd2; in_data = 4'h7;
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_acc", int'(acc), 0);
        check("midrst_acc_count", int'(acc_count), 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_old", int'(out_valid), 0);
        end

        // Accumulator: OR, OR, AND(3)
        @(posedge clk); #1 in_valid = 1'b1; in_op = 3'd3; in_data = 4'h6;
        @(posedge clk); #1 in_op = 3'd3; in_data = 4'hC;
        @(posedge clk); #1 in_op = 3'd2; in_data = 4'h3;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
`ifdef EXTINT_PIPE_ACC_EN
        check("acc_sum", int'(acc), 'h41);
        check("acc_cnt", int'(acc_count), 3);
`else
        check("acc_sum_off", int'(acc), 0);
        check("acc_cnt_off", int'(acc_count), 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 3'($urandom_range(0, 7));
            in_data   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        check("drain_done", q.size(), 0);
        @(negedge clk);
        check("drain_idle", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
